// File: rtl/id_ex_stage_reg_if.sv
// ID/EX boundary bundle: decoded ID-stage fields in, registered EX-stage fields out.
// The ID side drives through master; the pipeline register takes slave.
interface id_ex_stage_reg_if #(
    parameter int DATA_W = 32
);
    logic              RegWriteD;
    logic              MemtoRegD;
    logic              MemWriteD;
    logic              ALUSrcD;
    logic              isShiftD;
    logic              isJalD;
    logic              StopD;
    logic [4:0]        ALUControlD;
    logic [4:0]        rwD;
    logic [4:0]        rsD;
    logic [4:0]        rtD;
    logic [4:0]        shamtD;
    logic [DATA_W-1:0] PC4D;
    logic [DATA_W-1:0] RD1D;
    logic [DATA_W-1:0] RD2D;
    logic [DATA_W-1:0] ImmD;

    logic              RegWriteE;
    logic              MemtoRegE;
    logic              MemWriteE;
    logic              ALUSrcE;
    logic              isShiftE;
    logic              isJalE;
    logic              StopE;
    logic [4:0]        ALUControlE;
    logic [4:0]        rwE;
    logic [4:0]        rsE;
    logic [4:0]        rtE;
    logic [4:0]        shamtE;
    logic [DATA_W-1:0] PC4E;
    logic [DATA_W-1:0] RD1E;
    logic [DATA_W-1:0] RD2E;
    logic [DATA_W-1:0] ImmE;

    modport master (
        output RegWriteD, MemtoRegD, MemWriteD, ALUSrcD,
        output isShiftD, isJalD, StopD,
        output ALUControlD, rwD, rsD, rtD, shamtD,
        output PC4D, RD1D, RD2D, ImmD,
        input  RegWriteE, MemtoRegE, MemWriteE, ALUSrcE,
        input  isShiftE, isJalE, StopE,
        input  ALUControlE, rwE, rsE, rtE, shamtE,
        input  PC4E, RD1E, RD2E, ImmE
    );

    modport slave (
        input  RegWriteD, MemtoRegD, MemWriteD, ALUSrcD,
        input  isShiftD, isJalD, StopD,
        input  ALUControlD, rwD, rsD, rtD, shamtD,
        input  PC4D, RD1D, RD2D, ImmD,
        output RegWriteE, MemtoRegE, MemWriteE, ALUSrcE,
        output isShiftE, isJalE, StopE,
        output ALUControlE, rwE, rsE, rtE, shamtE,
        output PC4E, RD1E, RD2E, ImmE
    );
endinterface

// File: rtl/id_ex_stage_reg.sv
// ID/EX pipeline register with stall/flush/load-use bubbles and a
// halt-drain controller that freezes the front end after a stop reaches EX.
module id_ex_stage_reg #(
    parameter int DATA_W       = 32,
    parameter int DRAIN_CYCLES = 3
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              StallE,
    input  logic              FlushE,
    input  logic              isLWHazard,
    id_ex_stage_reg_if.slave  bus,
    output logic              ValidE,
    output logic              HoldFront,
    output logic              Halted
);
    localparam int CW = $clog2(DRAIN_CYCLES + 1);

    typedef enum logic [1:0] {
        RUN    = 2'd0,
        DRAIN  = 2'd1,
        HALTED = 2'd2
    } state_t;

    typedef struct packed {
        logic              RegWrite;
        logic              MemtoReg;
        logic              MemWrite;
        logic              ALUSrc;
        logic              isShift;
        logic              isJal;
        logic              Stop;
        logic [4:0]        ALUControl;
        logic [4:0]        rw;
        logic [4:0]        rs;
        logic [4:0]        rt;
        logic [4:0]        shamt;
        logic [DATA_W-1:0] PC4;
        logic [DATA_W-1:0] RD1;
        logic [DATA_W-1:0] RD2;
        logic [DATA_W-1:0] Imm;
        logic              Valid;
    } stage_t;

    state_t  state_q, state_n;
    logic [CW-1:0] cnt_q, cnt_n;
    stage_t  e_q, d_in;
    logic    do_cap, do_bub;

    // Gather the ID-stage inputs into one capture word
    always_comb begin
        d_in            = '0;
        d_in.RegWrite   = bus.RegWriteD;
        d_in.MemtoReg   = bus.MemtoRegD;
        d_in.MemWrite   = bus.MemWriteD;
        d_in.ALUSrc     = bus.ALUSrcD;
        d_in.isShift    = bus.isShiftD;
        d_in.isJal      = bus.isJalD;
        d_in.Stop       = bus.StopD;
        d_in.ALUControl = bus.ALUControlD;
        d_in.rw         = bus.rwD;
        d_in.rs         = bus.rsD;
        d_in.rt         = bus.rtD;
        d_in.shamt      = bus.shamtD;
        d_in.PC4        = bus.PC4D;
        d_in.RD1        = bus.RD1D;
        d_in.RD2        = bus.RD2D;
        d_in.Imm        = bus.ImmD;
        d_in.Valid      = 1'b1;
    end

    // Next-state, drain countdown and register load selection
    always_comb begin
        state_n = state_q;
        cnt_n   = cnt_q;
        do_cap  = 1'b0;
        do_bub  = 1'b0;
        unique case (state_q)
            RUN: begin
                if (FlushE) begin
                    do_bub = 1'b1;
                end else if (StallE) begin
                    do_bub = 1'b0;
                end else if (isLWHazard) begin
                    do_bub = 1'b1;
                end else begin
                    do_cap = 1'b1;
                    if (bus.StopD) begin
                        state_n = DRAIN;
                        cnt_n   = CW'(DRAIN_CYCLES);
                    end
                end
            end
            DRAIN: begin
                do_bub = 1'b1;
                if (cnt_q > CW'(1)) begin
                    cnt_n = cnt_q - CW'(1);
                end else begin
                    cnt_n   = '0;
                    state_n = HALTED;
                end
            end
            HALTED: begin
                do_bub = 1'b1;
                cnt_n  = '0;
            end
            default: begin
                do_bub  = 1'b1;
                state_n = RUN;
                cnt_n   = '0;
            end
        endcase
    end

    // Controller state register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= RUN;
            cnt_q   <= '0;
        end else begin
            state_q <= state_n;
            cnt_q   <= cnt_n;
        end
    end

    // E-stage register: capture, bubble, or hold
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            e_q <= '0;
        end else if (do_bub) begin
            e_q <= '0;
        end else if (do_cap) begin
            e_q <= d_in;
        end
    end

    assign bus.RegWriteE   = e_q.RegWrite;
    assign bus.MemtoRegE   = e_q.MemtoReg;
    assign bus.MemWriteE   = e_q.MemWrite;
    assign bus.ALUSrcE     = e_q.ALUSrc;
    assign bus.isShiftE    = e_q.isShift;
    assign bus.isJalE      = e_q.isJal;
    assign bus.StopE       = e_q.Stop;
    assign bus.ALUControlE = e_q.ALUControl;
    assign bus.rwE         = e_q.rw;
    assign bus.rsE         = e_q.rs;
    assign bus.rtE         = e_q.rt;
    assign bus.shamtE      = e_q.shamt;
    assign bus.PC4E        = e_q.PC4;
    assign bus.RD1E        = e_q.RD1;
    assign bus.RD2E        = e_q.RD2;
    assign bus.ImmE        = e_q.Imm;
    assign ValidE          = e_q.Valid;
    assign HoldFront       = (state_q != RUN);
    assign Halted          = (state_q == HALTED);
endmodule

// File: tb/tb_id_ex_stage_reg.sv
// Directed bench for the ID/EX register: reset, stall/flush, load-use,
// stop drain, stop conflicts and asynchronous reset during drain.
module tb_id_ex_stage_reg;
    localparam int DATA_W = 32;

    logic clk;
    logic reset;
    logic StallE;
    logic FlushE;
    logic isLWHazard;
    logic ValidE;
    logic HoldFront;
    logic Halted;

    int checks;
    int errors;

    id_ex_stage_reg_if #(.DATA_W(DATA_W)) bus ();

    id_ex_stage_reg #(
        .DATA_W      (DATA_W),
        .DRAIN_CYCLES(3)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .StallE    (StallE),
        .FlushE    (FlushE),
        .isLWHazard(isLWHazard),
        .bus       (bus),
        .ValidE    (ValidE),
        .HoldFront (HoldFront),
        .Halted    (Halted)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_d(input logic [4:0] rw, input logic [31:0] rd1,
                         input logic rwr, input logic stop);
        bus.RegWriteD   = rwr;
        bus.MemtoRegD   = 1'b1;
        bus.MemWriteD   = 1'b0;
        bus.ALUSrcD     = 1'b1;
        bus.isShiftD    = 1'b0;
        bus.isJalD      = 1'b0;
        bus.StopD       = stop;
        bus.ALUControlD = 5'd4;
        bus.rwD         = rw;
        bus.rsD         = 5'd1;
        bus.rtD         = 5'd2;
        bus.shamtD      = 5'd7;
        bus.PC4D        = 32'h0000_0040;
        bus.RD1D        = rd1;
        bus.RD2D        = 32'h0BAD_F00D;
        bus.ImmD        = 32'hFFFF_FFF0;
    endtask

    initial begin
        checks     = 0;
        errors     = 0;
        reset      = 1'b1;
        StallE     = 1'b0;
        FlushE     = 1'b0;
        isLWHazard = 1'b0;
        set_d(5'd31, 32'hDEAD_BEEF, 1'b1, 1'b1);

        #2;
        chk("rst_rwE", bus.rwE, 0);
        chk("rst_ValidE", ValidE, 0);
        chk("rst_HoldFront", HoldFront, 0);
        chk("rst_Halted", Halted, 0);
        step();
        set_d(5'd30, 32'hCAFE_0001, 1'b1, 1'b1);
        step();
        chk("rst_hold_RD1E", bus.RD1E, 0);
        chk("rst_hold_StopE", bus.StopE, 0);
        chk("rst_hold_RegWriteE", bus.RegWriteE, 0);
        chk("rst_hold_ImmE", bus.ImmE, 0);

        @(negedge clk);
        reset = 1'b0;
        set_d(5'd9, 32'h1234_5678, 1'b1, 1'b0);
        step();
        chk("cap_rwE", bus.rwE, 9);
        chk("cap_RD1E", bus.RD1E, 32'h1234_5678);
        chk("cap_ValidE", ValidE, 1);
        chk("cap_RegWriteE", bus.RegWriteE, 1);
        chk("cap_shamtE", bus.shamtE, 7);
        chk("cap_ImmE", bus.ImmE, 32'hFFFF_FFF0);

        StallE = 1'b1;
        set_d(5'd3, 32'h0000_AAAA, 1'b0, 1'b0);
        step();
        set_d(5'd4, 32'h0000_BBBB, 1'b0, 1'b0);
        step();
        chk("stall_rwE", bus.rwE, 9);
        chk("stall_RD1E", bus.RD1E, 32'h1234_5678);
        chk("stall_ValidE", ValidE, 1);
        chk("stall_RegWriteE", bus.RegWriteE, 1);

        FlushE = 1'b1;
        step();
        chk("flush_rwE", bus.rwE, 0);
        chk("flush_RD1E", bus.RD1E, 0);
        chk("flush_ValidE", ValidE, 0);
        chk("flush_MemtoRegE", bus.MemtoRegE, 0);

        FlushE     = 1'b0;
        StallE     = 1'b0;
        isLWHazard = 1'b1;
        set_d(5'd8, 32'h5555_0000, 1'b1, 1'b0);
        step();
        chk("lw_RegWriteE", bus.RegWriteE, 0);
        chk("lw_rwE", bus.rwE, 0);
        chk("lw_ValidE", ValidE, 0);

        isLWHazard = 1'b0;
        step();
        chk("lw_next_rwE", bus.rwE, 8);
        chk("lw_next_ValidE", ValidE, 1);
        chk("lw_next_RegWriteE", bus.RegWriteE, 1);

        FlushE = 1'b1;
        set_d(5'd12, 32'h0000_0012, 1'b1, 1'b1);
        step();
        chk("stopflush_StopE", bus.StopE, 0);
        chk("stopflush_HoldFront", HoldFront, 0);
        chk("stopflush_ValidE", ValidE, 0);

        FlushE = 1'b0;
        StallE = 1'b1;
        step();
        chk("stopstall_StopE", bus.StopE, 0);
        chk("stopstall_HoldFront", HoldFront, 0);

        StallE = 1'b0;
        step();
        chk("stop_N_StopE", bus.StopE, 1);
        chk("stop_N_HoldFront", HoldFront, 1);
        chk("stop_N_Halted", Halted, 0);
        chk("stop_N_rwE", bus.rwE, 12);

        set_d(5'd13, 32'h0000_0013, 1'b1, 1'b1);
        StallE = 1'b1;
        FlushE = 1'b1;
        step();
        chk("drain1_StopE", bus.StopE, 0);
        chk("drain1_ValidE", ValidE, 0);
        chk("drain1_Halted", Halted, 0);
        chk("drain1_HoldFront", HoldFront, 1);

        StallE = 1'b0;
        FlushE = 1'b0;
        step();
        chk("drain2_Halted", Halted, 0);
        chk("drain2_rwE", bus.rwE, 0);

        step();
        chk("drain3_Halted", Halted, 1);
        chk("drain3_HoldFront", HoldFront, 1);

        step();
        chk("halt_sticky_Halted", Halted, 1);
        chk("halt_rwE", bus.rwE, 0);
        chk("halt_ValidE", ValidE, 0);

        @(negedge clk);
        reset = 1'b1;
        #1;
        chk("rst_from_halt_Halted", Halted, 0);
        @(negedge clk);
        reset = 1'b0;
        set_d(5'd14, 32'h0000_0014, 1'b0, 1'b1);
        step();
        chk("stop2_StopE", bus.StopE, 1);
        set_d(5'd15, 32'h0000_0015, 1'b1, 1'b0);
        step();
        chk("stop2_cnt2_HoldFront", HoldFront, 1);
        #2;
        reset = 1'b1;
        #1;
        chk("async_Halted", Halted, 0);
        chk("async_HoldFront", HoldFront, 0);
        chk("async_StopE", bus.StopE, 0);

        @(negedge clk);
        reset = 1'b0;
        set_d(5'd17, 32'h7777_1717, 1'b1, 1'b0);
        step();
        chk("post_rst_rwE", bus.rwE, 17);
        chk("post_rst_RD1E", bus.RD1E, 32'h7777_1717);
        chk("post_rst_ValidE", ValidE, 1);
        chk("post_rst_HoldFront", HoldFront, 0);
        step();
        chk("post_rst_Halted", Halted, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
